mem_stage_lsu: RTL and testbench
================================

// Module: mem_stage_lsu
// PURPOSE
//  Memory-stage load/store unit. Consumes the M-stage bundle from the EX/MEM pipe register.
//  Drives a valid/ready data-memory port, then byte-aligns and sign/zero-extends load data.
//  Registers the result into the W-stage bundle and raises StallM while an access is outstanding.
// PARAMETERS
//  MAX_WAIT  255  max cycles in REQ or RESP before abort; 8-bit wait counter; 0 = no watchdog
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   asynchronous, active-low reset
//  RegWriteM      in   1   M-stage register-write enable
//  ResultSrcM     in   2   2'b01 = load; other values = non-load
//  MemWriteM      in   1   store
//  LUIInstrM      in   1   passed through to W
//  Funct3M        in   3   access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  RdM            in   5   destination register
//  ALUResultM     in   32  effective address / ALU result
//  WriteDataM     in   32  store data (rs2)
//  ExtImmM        in   32  passed through to W
//  PCPlus4M       in   32  passed through to W
//  dmem_req_valid out  1   request valid
//  dmem_req_ready in   1   memory accepts request
//  dmem_we        out  1   1 = store
//  dmem_addr      out  32  word-aligned address {ALUResultM[31:2],2'b00}
//  dmem_be        out  4   byte enables
//  dmem_wdata     out  32  store lanes
//  dmem_rsp_valid in   1   load data valid
//  dmem_rdata     in   32  load word
//  StallM         out  1   hold F/D/E/M stages this cycle
//  BusErrM        out  1   1-cycle pulse: watchdog abort
//  RegWriteW, ResultSrcW[1:0], LUIInstrW, RdW[4:0], ALUResultW, ReadDataW, ExtImmW, PCPlus4W  out  W bundle
// BEHAVIOUR
//  - Reset (async, rst=0): state IDLE; wait counter 0; all W outputs 0.
//    During reset dmem_req_valid=0, StallM=0, BusErrM=0 (combinational outputs forced low).
//  - memop = MemWriteM | (ResultSrcM==2'b01). MemWriteM has priority if both are set.
//  - FSM IDLE:
//    memop drives dmem_req_valid=1 combinationally.
//    Handshake (valid&ready): store -> done this cycle, stay IDLE; load -> RESP.
//    No handshake -> REQ.
//  - FSM REQ: hold all request outputs stable until ready. Then store -> IDLE, done; load -> RESP.
//  - FSM RESP: dmem_req_valid=0. rsp_valid -> done, capture data, -> IDLE.
//    rsp_valid is ignored outside RESP and in the handshake cycle.
//  - StallM = memop & ~done. Non-memop instructions: StallM=0, W captured next edge (1-cycle latency).
//  - W register:
//    If ~StallM, capture the M bundle; ReadDataW = extended load data (0 for non-loads).
//    If StallM, capture a bubble: RegWriteW=0; other W fields hold their values.
//  - Store lanes by addr[1:0]=a:
//    SB be=1<<a, wdata={4{WriteDataM[7:0]}}.
//    SH be=3<<a, wdata={2{WriteDataM[15:0]}}.
//    SW be=4'hF, wdata=WriteDataM.
//  - Load: select byte/half at offset a, sign-extend (B,H) or zero-extend (BU,HU). W is the full word.
//  - Watchdog: counter clears on entering REQ/RESP and increments each cycle there.
//    Reaching MAX_WAIT -> BusErrM pulse, done forced, RegWriteW=0, -> IDLE.
//    A late rsp_valid is then ignored.
//  - Reset mid-access: request dropped immediately. The memory side must tolerate an abandoned request.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined:
//    H with a[0]=1, or W with a!=0: no request issued; MisalignM (extra out, 1) pulses.
//    Instruction retires next edge with RegWriteW=0; StallM=0.
//  MISALIGN_TRAP_EN undefined:
//    No MisalignM port. Misaligned access behaves as aligned-down
//    (H uses a&2'b10, W uses a=0).
// TESTING
//  1. Non-memop ALUResultM=32'h1234, RegWriteM=1, RdM=5 -> StallM=0; next edge ALUResultW=32'h1234, RdW=5, RegWriteW=1.
//  2. SB addr 32'h103, WriteDataM=32'hAB, ready=1 -> same cycle be=4'b1000, wdata=32'hABABABAB, StallM=0.
//  3. LB addr 32'h102, ready after 2 cycles, rsp 3 cycles later with rdata=32'h00F00000
//     -> StallM high 5 cycles, ReadDataW=32'hFFFFFFF0.
//     Repeat with LBU -> ReadDataW=32'h000000F0.
//  4. LW, rsp_valid never asserted, MAX_WAIT=4 -> BusErrM pulses after 4 RESP cycles, RegWriteW=0, FSM IDLE.
//  5. rst low in RESP, then rsp_valid after release -> req_valid=0, W zeroed, response ignored, StallM=0.
//  6. LW addr 32'h102:
//     MISALIGN_TRAP_EN -> no request, MisalignM=1, RegWriteW=0.
//     Without -> dmem_addr=32'h100, ReadDataW=rdata.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: valid/ready data-memory port, load alignment/extension, W-stage register.
// Optional MISALIGN_TRAP_EN: misaligned H/W accesses trap (MisalignM) instead of aligning down.
module mem_stage_lsu #(
   parameter int MAX_WAIT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RegWriteM,
   input  logic [1:0]  ResultSrcM,
   input  logic        MemWriteM,
   input  logic        LUIInstrM,
   input  logic [2:0]  Funct3M,
   input  logic [4:0]  RdM,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   input  logic [31:0] ExtImmM,
   input  logic [31:0] PCPlus4M,
   output logic        dmem_req_valid,
   input  logic        dmem_req_ready,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_rsp_valid,
   input  logic [31:0] dmem_rdata,
   output logic        StallM,
   output logic        BusErrM,
`ifdef MISALIGN_TRAP_EN
   output logic        MisalignM,
`endif
   output logic        RegWriteW,
   output logic [1:0]  ResultSrcW,
   output logic        LUIInstrW,
   output logic [4:0]  RdW,
   output logic [31:0] ALUResultW,
   output logic [31:0] ReadDataW,
   output logic [31:0] ExtImmW,
   output logic [31:0] PCPlus4W
);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   state_t      state, state_n;
   logic [7:0]  wait_cnt;
   logic        is_store, is_load, memop, misal;
   logic [1:0]  a, off;
   logic        req_c, done, rsp_take, abort, timeout;
   logic [31:0] shifted, ld_ext;

   // Stores win when both store and load encodings are present.
   assign is_store = MemWriteM;
   assign is_load  = ~MemWriteM & (ResultSrcM == 2'b01);
   assign memop    = is_store | is_load;
   assign a        = ALUResultM[1:0];

`ifdef MISALIGN_TRAP_EN
   assign misal = memop & (((Funct3M[1:0] == 2'b01) & a[0]) |
                           ((Funct3M[1:0] == 2'b10) & (a != 2'b00)));
`else
   assign misal = 1'b0;
`endif

   // Effective lane offset; misaligned halves/words are aligned down.
   always_comb begin
      off = 2'b00;
      case (Funct3M[1:0])
         2'b00:   off = a;
         2'b01:   off = {a[1], 1'b0};
         default: off = 2'b00;
      endcase
   end

   assign dmem_addr = {ALUResultM[31:2], 2'b00};
   assign dmem_we   = MemWriteM;

   always_comb begin
      dmem_be    = 4'hF;
      dmem_wdata = WriteDataM;
      case (Funct3M[1:0])
         2'b00: begin
            dmem_be    = 4'b0001 << off;
            dmem_wdata = {4{WriteDataM[7:0]}};
         end
         2'b01: begin
            dmem_be    = 4'b0011 << off;
            dmem_wdata = {2{WriteDataM[15:0]}};
         end
         default: ;
      endcase
   end

   assign shifted = dmem_rdata >> {off, 3'b000};

   always_comb begin
      ld_ext = shifted;
      case (Funct3M)
         3'b000:  ld_ext = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  ld_ext = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  ld_ext = {24'd0, shifted[7:0]};
         3'b101:  ld_ext = {16'd0, shifted[15:0]};
         default: ld_ext = shifted;
      endcase
   end

   assign timeout = (MAX_WAIT != 0) && (state != IDLE) && (wait_cnt == WAIT_LAST);

   always_comb begin
      state_n  = state;
      req_c    = 1'b0;
      done     = 1'b0;
      rsp_take = 1'b0;
      abort    = 1'b0;
      case (state)
         IDLE: begin
            if (misal) begin
               done = 1'b1;
            end else if (memop) begin
               req_c = 1'b1;
               if (dmem_req_ready) begin
                  if (is_store) done = 1'b1;
                  else          state_n = RESP;
               end else begin
                  state_n = REQ;
               end
            end
         end
         REQ: begin
            req_c = 1'b1;
            if (dmem_req_ready) begin
               if (is_store) begin
                  done    = 1'b1;
                  state_n = IDLE;
               end else begin
                  state_n = RESP;
               end
            end else if (timeout) begin
               abort = 1'b1;
            end
         end
         RESP: begin
            if (dmem_rsp_valid) begin
               done     = 1'b1;
               rsp_take = 1'b1;
               state_n  = IDLE;
            end else if (timeout) begin
               abort = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
      // Watchdog abort retires the instruction without a register write.
      if (abort) begin
         done    = 1'b1;
         state_n = IDLE;
      end
   end

   // Combinational outputs are held low while reset is asserted.
   assign dmem_req_valid = rst & req_c;
   assign StallM         = rst & memop & ~done;
   assign BusErrM        = rst & abort;
`ifdef MISALIGN_TRAP_EN
   assign MisalignM      = rst & misal;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         wait_cnt <= 8'd0;
      end else begin
         state <= state_n;
         if (state_n != state)  wait_cnt <= 8'd0;
         else if (state != IDLE) wait_cnt <= wait_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         RegWriteW  <= 1'b0;
         ResultSrcW <= 2'b00;
         LUIInstrW  <= 1'b0;
         RdW        <= 5'd0;
         ALUResultW <= 32'd0;
         ReadDataW  <= 32'd0;
         ExtImmW    <= 32'd0;
         PCPlus4W   <= 32'd0;
      end else if (!StallM) begin
         RegWriteW  <= RegWriteM & ~abort & ~misal;
         ResultSrcW <= ResultSrcM;
         LUIInstrW  <= LUIInstrM;
         RdW        <= RdM;
         ALUResultW <= ALUResultM;
         ReadDataW  <= rsp_take ? ld_ext : 32'd0;
         ExtImmW    <= ExtImmM;
         PCPlus4W   <= PCPlus4M;
      end else begin
         RegWriteW  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: single-cycle vector table plus multi-cycle load, watchdog and reset sequences.
module tb_mem_stage_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        RegWriteM, MemWriteM, LUIInstrM;
   logic [1:0]  ResultSrcM;
   logic [2:0]  Funct3M;
   logic [4:0]  RdM;
   logic [31:0] ALUResultM, WriteDataM, ExtImmM, PCPlus4M;
   logic        dmem_req_valid, dmem_req_ready, dmem_we, dmem_rsp_valid;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic        StallM, BusErrM;
`ifdef MISALIGN_TRAP_EN
   logic        MisalignM;
`endif
   logic        RegWriteW, LUIInstrW;
   logic [1:0]  ResultSrcW;
   logic [4:0]  RdW;
   logic [31:0] ALUResultW, ReadDataW, ExtImmW, PCPlus4W;

   always #5 clk = ~clk;

   mem_stage_lsu #(.MAX_WAIT(4)) dut (
      .clk(clk), .rst(rst),
      .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
      .LUIInstrM(LUIInstrM), .Funct3M(Funct3M), .RdM(RdM),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .ExtImmM(ExtImmM), .PCPlus4M(PCPlus4M),
      .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
      .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
      .StallM(StallM), .BusErrM(BusErrM),
`ifdef MISALIGN_TRAP_EN
      .MisalignM(MisalignM),
`endif
      .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .LUIInstrW(LUIInstrW), .RdW(RdW),
      .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .ExtImmW(ExtImmW), .PCPlus4W(PCPlus4W)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bubble();
      RegWriteM = 1'b0; ResultSrcM = 2'b00; MemWriteM = 1'b0; LUIInstrM = 1'b0;
      Funct3M = 3'b000; RdM = 5'd0; ALUResultM = 32'd0; WriteDataM = 32'd0;
      ExtImmM = 32'd0; PCPlus4M = 32'd0;
      dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rdata = 32'd0;
   endtask

   // Runs one load until StallM drops; ready is high from cycle rdy_at, rsp_valid pulses at rsp_at.
   task automatic run_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata,
                           input int rdy_at, input int rsp_at,
                           output int stalls, output int berr_at, output logic [31:0] addr0,
                           output logic val0, output logic mis0, output logic val1);
      bit fin = 0;
      ResultSrcM = 2'b01; MemWriteM = 1'b0; RegWriteM = 1'b1; Funct3M = f3; RdM = 5'd7;
      ALUResultM = addr; dmem_rdata = rdata;
      stalls = 0; berr_at = -1; addr0 = 32'd0; val0 = 1'b0; mis0 = 1'b0; val1 = 1'b0;
      for (int i = 0; i < 30 && !fin; i++) begin
         dmem_req_ready = (i >= rdy_at);
         dmem_rsp_valid = (i == rsp_at);
         #1;
         if (i == 0) begin
            addr0 = dmem_addr;
            val0  = dmem_req_valid;
`ifdef MISALIGN_TRAP_EN
            mis0  = MisalignM;
`endif
         end
         if (i == 1) val1 = dmem_req_valid;
         if (BusErrM) berr_at = i;
         if (!StallM) fin = 1;
         else         stalls++;
         tick();
      end
      if (!fin) chk("load_bound", 32'd0, 32'd1);
      bubble();
   endtask

   typedef struct {
      logic [1:0]  rs;
      logic        mw;
      logic        rw;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic [31:0] alu;
      logic [31:0] wd;
      logic        ev;
      logic [3:0]  ebe;
      logic [31:0] ewd;
      logic [31:0] ead;
   } vec_t;

   vec_t vt[9];
   int          st, ba;
   logic [31:0] ad0;
   logic        v0, m0, v1;

   initial begin
      vt[0] = '{2'b00, 1'b0, 1'b1, 3'b000, 5'd5,  32'h0000_1234, 32'h0,         1'b0, 4'h0,    32'h0,         32'h0};
      vt[1] = '{2'b00, 1'b1, 1'b0, 3'b000, 5'd0,  32'h0000_0103, 32'h0000_00AB, 1'b1, 4'b1000, 32'hABABABAB, 32'h100};
      vt[2] = '{2'b00, 1'b1, 1'b0, 3'b000, 5'd0,  32'h0000_0100, 32'h1234_5678, 1'b1, 4'b0001, 32'h78787878, 32'h100};
      vt[3] = '{2'b00, 1'b1, 1'b0, 3'b001, 5'd0,  32'h0000_0102, 32'h0000_BEEF, 1'b1, 4'b1100, 32'hBEEFBEEF, 32'h100};
      vt[4] = '{2'b00, 1'b1, 1'b0, 3'b001, 5'd0,  32'h0000_0200, 32'hCAFE_1234, 1'b1, 4'b0011, 32'h12341234, 32'h200};
      vt[5] = '{2'b00, 1'b1, 1'b0, 3'b010, 5'd0,  32'h0000_0204, 32'hDEAD_BEEF, 1'b1, 4'b1111, 32'hDEADBEEF, 32'h204};
      vt[6] = '{2'b10, 1'b0, 1'b1, 3'b000, 5'd31, 32'hFFFF_0000, 32'h0,         1'b0, 4'h0,    32'h0,         32'h0};
      vt[7] = '{2'b00, 1'b1, 1'b0, 3'b000, 5'd0,  32'h0000_0401, 32'h0000_005A, 1'b1, 4'b0010, 32'h5A5A5A5A, 32'h400};
      vt[8] = '{2'b01, 1'b1, 1'b0, 3'b010, 5'd0,  32'h0000_0010, 32'h1122_3344, 1'b1, 4'b1111, 32'h11223344, 32'h010};

      // Reset: combinational outputs forced low even with a load presented.
      bubble();
      rst = 1'b0;
      ResultSrcM = 2'b01; RegWriteM = 1'b1; dmem_req_ready = 1'b0;
      #2;
      chk("rst_req_valid", {31'd0, dmem_req_valid}, 32'd0);
      chk("rst_stall",     {31'd0, StallM},         32'd0);
      chk("rst_buserr",    {31'd0, BusErrM},        32'd0);
      chk("rst_regwritew", {31'd0, RegWriteW},      32'd0);
      chk("rst_aluresw",   ALUResultW,              32'd0);
      bubble();
      tick(); tick();
      rst = 1'b1;

      for (int i = 0; i < 9; i++) begin
         RegWriteM = vt[i].rw; ResultSrcM = vt[i].rs; MemWriteM = vt[i].mw; Funct3M = vt[i].f3;
         RdM = vt[i].rd; ALUResultM = vt[i].alu; WriteDataM = vt[i].wd;
         LUIInstrM = i[0]; ExtImmM = 32'hE000_0000 | i; PCPlus4M = 32'h0000_4000 + i;
         dmem_req_ready = 1'b1;
         #1;
         chk($sformatf("v%0d_stall", i),     {31'd0, StallM},         32'd0);
         chk($sformatf("v%0d_req_valid", i), {31'd0, dmem_req_valid}, {31'd0, vt[i].ev});
         if (vt[i].ev) begin
            chk($sformatf("v%0d_be", i),    {28'd0, dmem_be}, {28'd0, vt[i].ebe});
            chk($sformatf("v%0d_wdata", i), dmem_wdata,       vt[i].ewd);
            chk($sformatf("v%0d_addr", i),  dmem_addr,        vt[i].ead);
            chk($sformatf("v%0d_we", i),    {31'd0, dmem_we}, 32'd1);
         end
         tick();
         chk($sformatf("v%0d_regwritew", i), {31'd0, RegWriteW}, {31'd0, vt[i].rw});
         chk($sformatf("v%0d_rdw", i),       {27'd0, RdW},       {27'd0, vt[i].rd});
         chk($sformatf("v%0d_aluresw", i),   ALUResultW,         vt[i].alu);
         chk($sformatf("v%0d_readdataw", i), ReadDataW,          32'd0);
         chk($sformatf("v%0d_extimmw", i),   ExtImmW,            32'hE000_0000 | i);
         chk($sformatf("v%0d_pcplus4w", i),  PCPlus4W,           32'h0000_4000 + i);
         chk($sformatf("v%0d_luiw", i),      {31'd0, LUIInstrW}, {31'd0, i[0]});
         chk($sformatf("v%0d_ressrcw", i),   {30'd0, ResultSrcW}, {30'd0, vt[i].rs});
      end
      bubble();

      run_load(3'b000, 32'h102, 32'h00F0_0000, 2, 5, st, ba, ad0, v0, m0, v1);
      chk("lb_stalls",   st,                    32'd5);
      chk("lb_req_hold", {31'd0, v1},           32'd1);
      chk("lb_data",     ReadDataW,             32'hFFFF_FFF0);
      chk("lb_regwrite", {31'd0, RegWriteW},    32'd1);
      chk("lb_rdw",      {27'd0, RdW},          32'd7);

      run_load(3'b100, 32'h102, 32'h00F0_0000, 2, 5, st, ba, ad0, v0, m0, v1);
      chk("lbu_stalls", st,        32'd5);
      chk("lbu_data",   ReadDataW, 32'h0000_00F0);

      run_load(3'b001, 32'h102, 32'h8001_0000, 0, 1, st, ba, ad0, v0, m0, v1);
      chk("lh_stalls",     st,           32'd1);
      chk("lh_resp_noreq", {31'd0, v1},  32'd0);
      chk("lh_data",       ReadDataW,    32'hFFFF_8001);

      run_load(3'b101, 32'h100, 32'h1234_9ABC, 0, 1, st, ba, ad0, v0, m0, v1);
      chk("lhu_data", ReadDataW, 32'h0000_9ABC);

      // Watchdog: response never arrives.
      run_load(3'b010, 32'h300, 32'h0000_0077, 0, 99, st, ba, ad0, v0, m0, v1);
      chk("wd_stalls",   st,                 32'd4);
      chk("wd_buserr_at", ba,                32'd4);
      chk("wd_regwrite", {31'd0, RegWriteW}, 32'd0);
      dmem_rsp_valid = 1'b1; dmem_rdata = 32'h0000_0077;
      #1;
      chk("wd_late_stall", {31'd0, StallM}, 32'd0);
      tick();
      chk("wd_late_data", ReadDataW, 32'd0);
      bubble();
      MemWriteM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h500; dmem_req_ready = 1'b1;
      #1;
      chk("wd_idle_store", {31'd0, StallM}, 32'd0);
      tick();
      bubble();

      // Reset while waiting for a response.
      RegWriteM = 1'b1; RdM = 5'd9; ALUResultM = 32'h5555;
      tick();
      ResultSrcM = 2'b01; Funct3M = 3'b010; ALUResultM = 32'h600; dmem_req_ready = 1'b1;
      tick();
      #1;
      chk("mr_stall_resp", {31'd0, StallM}, 32'd1);
      chk("mr_aluw_held",  ALUResultW,      32'h5555);
      rst = 1'b0;
      #1;
      chk("mr_req_valid", {31'd0, dmem_req_valid}, 32'd0);
      chk("mr_stall",     {31'd0, StallM},         32'd0);
      chk("mr_aluw_zero", ALUResultW,              32'd0);
      chk("mr_rdw_zero",  {27'd0, RdW},            32'd0);
      bubble();
      tick();
      rst = 1'b1;
      dmem_rsp_valid = 1'b1; dmem_rdata = 32'hDEAD_0001;
      #1;
      chk("mr_post_stall", {31'd0, StallM},         32'd0);
      chk("mr_post_req",   {31'd0, dmem_req_valid}, 32'd0);
      tick();
      chk("mr_post_data",  ReadDataW,               32'd0);
      chk("mr_post_rw",    {31'd0, RegWriteW},      32'd0);
      bubble();

      run_load(3'b010, 32'h102, 32'h89AB_CDEF, 0, 1, st, ba, ad0, v0, m0, v1);
`ifdef MISALIGN_TRAP_EN
      chk("mis_stalls",   st,                 32'd0);
      chk("mis_no_req",   {31'd0, v0},        32'd0);
      chk("mis_pulse",    {31'd0, m0},        32'd1);
      chk("mis_regwrite", {31'd0, RegWriteW}, 32'd0);
`else
      chk("mis_addr",     ad0,                32'h100);
      chk("mis_stalls",   st,                 32'd1);
      chk("mis_data",     ReadDataW,          32'h89AB_CDEF);
      chk("mis_regwrite", {31'd0, RegWriteW}, 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
